// File: rtl/dds_freq_ctrl.sv
// Frequency-word controller for the DDS: debounced manual stepping plus a timed linear sweep.
// Define DDS_SWEEP_TRI_EN for a triangle sweep; the default build wraps as a sawtooth.
module dds_freq_ctrl #(
    parameter int unsigned      FW_W    = 32,
    parameter logic [FW_W-1:0]  F_INIT  = 32'd1000,
    parameter logic [FW_W-1:0]  F_MIN   = 32'd100,
    parameter logic [FW_W-1:0]  F_MAX   = 32'd100000,
    parameter logic [FW_W-1:0]  STEP    = 32'd100,
    parameter int unsigned      DEB_CNT = 240000,
    parameter int unsigned      DWELL   = 24000
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            key_plus,
    input  logic            key_down,
    input  logic            sweep_en,
    input  logic [1:0]      step_sel,
    output logic [FW_W-1:0] freq_word,
    output logic            freq_upd,
    output logic            sweeping,
    output logic [1:0]      led
);

    localparam int unsigned DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CNT - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [FW_W:0]    FMAX_X     = {1'b0, F_MAX};
    localparam logic [FW_W:0]    FMIN_X     = {1'b0, F_MIN};

`ifdef DDS_SWEEP_TRI_EN
    typedef enum logic [1:0] {StIdle, StSweepUp, StSweepDn} state_e;
`else
    typedef enum logic [1:0] {StIdle, StSweepUp} state_e;
`endif

    state_e                     state_q, state_d;
    logic [2:0]                 sync1_q, sync2_q;
    logic [1:0]                 deb_q, deb_d;
    logic [1:0][DEB_W-1:0]      deb_cnt_q, deb_cnt_d;
    logic [1:0]                 press_q, press_d;
    logic [DW_W-1:0]            dwell_q, dwell_d;
    logic [FW_W-1:0]            freq_q, freq_d;
    logic                       upd_q, upd_d;
    logic                       sweep_s;
    logic [FW_W:0]              step_x, sum_x, diff_x;
    logic [FW_W-1:0]            up_sat, dn_sat;

    // Bit 0 = key_plus, bit 1 = key_down, bit 2 = sweep_en.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 3'b011;
            sync2_q <= 3'b011;
        end else begin
            sync1_q <= {sweep_en, key_down, key_plus};
            sync2_q <= sync1_q;
        end
    end

    assign sweep_s = sync2_q[2];

    // A key level is accepted only after DEB_CNT consecutive cycles away from the debounced level.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                deb_d[i]     = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
        end
        press_d = deb_q & ~deb_d;
    end

    always_comb begin
        step_x = {1'b0, STEP} << {step_sel, 1'b0};
        sum_x  = {1'b0, freq_q} + step_x;
        diff_x = {1'b0, freq_q} - step_x;
        up_sat = (sum_x > FMAX_X) ? F_MAX : sum_x[FW_W-1:0];
        dn_sat = (step_x > {1'b0, freq_q} || diff_x < FMIN_X) ? F_MIN : diff_x[FW_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        dwell_d = dwell_q;
        unique case (state_q)
            StIdle: begin
                if (press_q[0] && !press_q[1]) begin
                    freq_d = up_sat;
                end else if (press_q[1] && !press_q[0]) begin
                    freq_d = dn_sat;
                end
                if (sweep_s) begin
                    state_d = StSweepUp;
                    dwell_d = '0;
                end
            end
            StSweepUp: begin
                if (!sweep_s) begin
                    state_d = StIdle;
                    dwell_d = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
`ifdef DDS_SWEEP_TRI_EN
                    // Already at the top: reverse and take the down step in this same slot.
                    if (freq_q == F_MAX) begin
                        freq_d  = dn_sat;
                        state_d = StSweepDn;
                    end else begin
                        freq_d = up_sat;
                        if (sum_x > FMAX_X) state_d = StSweepDn;
                    end
`else
                    freq_d = (sum_x > FMAX_X) ? F_MIN : sum_x[FW_W-1:0];
`endif
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
`ifdef DDS_SWEEP_TRI_EN
            StSweepDn: begin
                if (!sweep_s) begin
                    state_d = StIdle;
                    dwell_d = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (freq_q == F_MIN) begin
                        freq_d  = up_sat;
                        state_d = StSweepUp;
                    end else begin
                        freq_d = dn_sat;
                        if (step_x > {1'b0, freq_q} || diff_x < FMIN_X) state_d = StSweepUp;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
        upd_d = (freq_d != freq_q);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= StIdle;
            deb_q     <= 2'b11;
            deb_cnt_q <= '0;
            press_q   <= 2'b00;
            dwell_q   <= '0;
            freq_q    <= F_INIT;
            upd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            press_q   <= press_d;
            dwell_q   <= dwell_d;
            freq_q    <= freq_d;
            upd_q     <= upd_d;
        end
    end

    assign freq_word = freq_q;
    assign freq_upd  = upd_q;
    assign sweeping  = (state_q != StIdle);
    assign led       = {~(freq_q == F_MIN), ~(freq_q == F_MAX)};

endmodule

// File: tb/tb_dds_freq_ctrl.sv
// Self-checking bench for dds_freq_ctrl: directed and randomised key/sweep stimulus against
// a value-level model of the frequency word.
module tb_dds_freq_ctrl;

    localparam int FMIN = 100, FMAX = 200, FSTEP = 10, FINIT = 150;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n, key_plus, key_down, sweep_en;
    logic [1:0]  step_sel;
    logic [31:0] freq_word;
    logic        freq_upd, sweeping;
    logic [1:0]  led;

    int vectors = 0, errors = 0, cyc = 0, upd_cnt = 0;
    int upd_val[$];
    int upd_cyc[$];
    int exp_fw = FINIT;
    int mf;
`ifdef DDS_SWEEP_TRI_EN
    bit mup;
`endif
    int mult[4] = '{1, 4, 16, 64};

    dds_freq_ctrl #(
        .FW_W(32), .F_INIT(32'd150), .F_MIN(32'd100), .F_MAX(32'd200),
        .STEP(32'd10), .DEB_CNT(4), .DWELL(3)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_plus(key_plus), .key_down(key_down),
        .sweep_en(sweep_en), .step_sel(step_sel), .freq_word(freq_word), .freq_upd(freq_upd),
        .sweeping(sweeping), .led(led)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
    function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run(int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            cyc++;
            if (freq_upd === 1'b1) begin
                upd_cnt++;
                upd_val.push_back(int'(freq_word));
                upd_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic clear_log();
        upd_cnt = 0;
        upd_val.delete();
        upd_cyc.delete();
    endtask

    task automatic press(bit p, bit d, int hold);
        int old, s;
        old = exp_fw;
        s   = FSTEP * mult[step_sel];
        if (p && !d) exp_fw = imin(exp_fw + s, FMAX);
        else if (d && !p) exp_fw = imax(exp_fw - s, FMIN);
        clear_log();
        key_plus = !p;
        key_down = !d;
        run(hold);
        key_plus = 1'b1;
        key_down = 1'b1;
        run(14);
        check("press_val", freq_word, exp_fw);
        check("press_upd", upd_cnt, (exp_fw != old) ? 1 : 0);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        run(2);
        sys_rst_n = 1'b1;
        exp_fw = FINIT;
        run(2);
    endtask

    task automatic model_step(int s);
`ifdef DDS_SWEEP_TRI_EN
        if (mup) begin
            if (mf == FMAX) begin mup = 0; mf = imax(mf - s, FMIN); end
            else if (mf + s > FMAX) begin mf = FMAX; mup = 0; end
            else mf = mf + s;
        end else begin
            if (mf == FMIN) begin mup = 1; mf = imin(mf + s, FMAX); end
            else if (mf - s < FMIN) begin mf = FMIN; mup = 1; end
            else mf = mf - s;
        end
`else
        mf = (mf + s <= FMAX) ? mf + s : FMIN;
`endif
    endtask

    task automatic sweep_run(int cycles, bit with_keys, bit check_gap, int min_cnt);
        int s, prev, k;
        s  = FSTEP * mult[step_sel];
        mf = exp_fw;
`ifdef DDS_SWEEP_TRI_EN
        mup = 1;
`endif
        clear_log();
        sweep_en = 1'b1;
        run(4);
        check("sweeping_on", {31'd0, sweeping}, 32'd1);
        if (with_keys) begin
            key_plus = 1'b0;
            run(15);
            key_plus = 1'b1;
            run(cycles - 19);
        end else begin
            run(cycles - 4);
        end
        sweep_en = 1'b0;
        run(6);
        foreach (upd_val[i]) begin
            prev = mf;
            k = 0;
            // Saturated steps leave the word unchanged and produce no update.
            do begin
                model_step(s);
                k++;
            end while (mf == prev && k < 4);
            check("sweep_val", upd_val[i], mf);
            if (check_gap && i > 0) check("sweep_gap", upd_cyc[i] - upd_cyc[i-1], 3);
        end
        check("sweep_cnt", {31'd0, upd_cnt >= min_cnt}, 32'd1);
        if (upd_val.size() > 0) exp_fw = upd_val[$];
        clear_log();
        run(10);
        check("sweep_off", {31'd0, sweeping}, 32'd0);
        check("sweep_hold_upd", upd_cnt, 0);
        check("sweep_hold_val", freq_word, exp_fw);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        key_plus  = 1'b1;
        key_down  = 1'b1;
        sweep_en  = 1'b0;
        step_sel  = 2'd0;
        run(2);
        check("rst_freq", freq_word, FINIT);
        check("rst_upd", {31'd0, freq_upd}, 32'd0);
        check("rst_sweeping", {31'd0, sweeping}, 32'd0);
        check("rst_led", {30'd0, led}, 32'd3);
        sys_rst_n = 1'b1;
        run(3);

        // Held key steps once; large down step saturates at the floor.
        press(1, 0, 20);
        check("plus_160", freq_word, 160);
        step_sel = 2'd2;
        press(0, 1, 20);
        check("down_floor", freq_word, 100);
        check("led_floor", {30'd0, led}, 32'd1);

        clear_log();
        for (int i = 0; i < 15; i++) begin
            key_plus = ~key_plus;
            run(2);
        end
        key_plus = 1'b1;
        run(12);
        check("bounce_upd", upd_cnt, 0);
        check("bounce_val", freq_word, exp_fw);

        step_sel = 2'd0;
        press(1, 1, 20);

        for (int n = 0; n < 16; n++) begin
            int kk;
            step_sel = 2'($urandom_range(0, 3));
            kk = $urandom_range(0, 2);
            press(kk == 0 || kk == 2, kk == 1 || kk == 2, $urandom_range(10, 30));
        end

        do_reset();
        step_sel = 2'd1;
        press(1, 0, 12);
        check("up_190", freq_word, 190);
        press(1, 0, 12);
        check("up_ceiling", freq_word, 200);
        check("led_ceiling", {30'd0, led}, 32'd2);
        press(1, 0, 12);

        do_reset();
        step_sel = 2'd0;
        press(1, 0, 12);
        press(1, 0, 12);
        press(1, 0, 12);
        check("sweep_start", freq_word, 180);
        sweep_run(60, 1, 1, 15);

        step_sel = 2'($urandom_range(0, 2));
        sweep_run(50, 0, 0, 0);

        // Asynchronous reset in the middle of a sweep.
        sweep_en = 1'b1;
        run(20);
        #2 sys_rst_n = 1'b0;
        #1;
        check("arst_freq", freq_word, FINIT);
        check("arst_upd", {31'd0, freq_upd}, 32'd0);
        check("arst_sweeping", {31'd0, sweeping}, 32'd0);
        check("arst_led", {30'd0, led}, 32'd3);
        sweep_en = 1'b0;
        run(3);
        sys_rst_n = 1'b1;
        run(3);
        check("post_rst_freq", freq_word, FINIT);
        check("post_rst_sweeping", {31'd0, sweeping}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
